// File: rtl/wbuff_tap_load_seq.sv
// Weight-buffer tap loader: takes one load command, streams consecutive SRAM reads
// and pulses the one-hot tap capture enable one cycle after each read address.
module wbuff_tap_load_seq #(
  parameter int NB_TAPS      = 11,
  parameter int BUFFER_DEPTH = 72,
  parameter int ADDR_W       = 7,
  parameter int CNT_W        = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [ADDR_W-1:0]  cmd_base_addr,
  input  logic [CNT_W-1:0]   cmd_n_taps,
  input  logic               cmd_clear,
  input  logic               pause,
  output logic               buf_rEn_n,
  output logic [ADDR_W-1:0]  buf_rAddr,
  output logic [NB_TAPS-1:0] weight_load_en,
  output logic               clear_all_wregs,
  output logic               busy,
  output logic               done,
  output logic               cmd_err
);

  typedef enum logic [1:0] {IDLE, CLEAR, ISSUE, DRAIN} state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [CNT_W-1:0]   n_q, n_d;
  logic [CNT_W-1:0]   k_q, k_d;
  logic               rEn_n_q, rEn_n_d;
  logic [NB_TAPS-1:0] ld_q, ld_d;
  logic               clr_q, clr_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               accept;
  logic               n_bad;
  logic [ADDR_W-1:0]  base_wrap;
  logic [ADDR_W-1:0]  addr_next;

  assign accept    = cmd_valid && (state_q == IDLE);
  assign n_bad     = (cmd_n_taps == '0) || (cmd_n_taps > CNT_W'(NB_TAPS));
  assign base_wrap = (cmd_base_addr >= ADDR_W'(BUFFER_DEPTH)) ?
                     cmd_base_addr - ADDR_W'(BUFFER_DEPTH) : cmd_base_addr;
  assign addr_next = (addr_q == ADDR_W'(BUFFER_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

  // Outputs are registered, so each state decides what the bank sees next cycle;
  // k_q counts reads already issued, so a presented read belongs to tap k_q-1.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    n_d     = n_q;
    k_d     = k_q;
    addr_d  = addr_q;
    rEn_n_d = 1'b1;
    clr_d   = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ld_d    = rEn_n_q ? '0 : (NB_TAPS'(1) << (k_q - CNT_W'(1)));
    case (state_q)
      IDLE: begin
        busy_d = accept;
        if (accept) begin
          base_d = base_wrap;
          n_d    = cmd_n_taps;
          if (n_bad) begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end else if (cmd_clear) begin
            clr_d   = 1'b1;
            state_d = CLEAR;
          end else begin
            rEn_n_d = 1'b0;
            addr_d  = base_wrap;
            k_d     = CNT_W'(1);
            state_d = ISSUE;
          end
        end
      end
      CLEAR: begin
        rEn_n_d = 1'b0;
        addr_d  = base_q;
        k_d     = CNT_W'(1);
        state_d = ISSUE;
      end
      ISSUE: begin
        if (k_q == n_q) begin
          state_d = DRAIN;
        end else if (!pause) begin
          rEn_n_d = 1'b0;
          addr_d  = addr_next;
          k_d     = k_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      n_q     <= '0;
      k_q     <= '0;
      addr_q  <= '0;
      rEn_n_q <= 1'b1;
      ld_q    <= '0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      n_q     <= n_d;
      k_q     <= k_d;
      addr_q  <= addr_d;
      rEn_n_q <= rEn_n_d;
      ld_q    <= ld_d;
      clr_q   <= clr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign cmd_ready       = (state_q == IDLE);
  assign buf_rEn_n       = rEn_n_q;
  assign buf_rAddr       = addr_q;
  assign weight_load_en  = ld_q;
  assign clear_all_wregs = clr_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign cmd_err         = err_q;

endmodule

// File: tb/tb_wbuff_tap_load_seq.sv
// Bench for wbuff_tap_load_seq: directed command table, pause and reset sequences,
// and random commands checked cycle by cycle against a timeline model.
module tb_wbuff_tap_load_seq;
  localparam int NB_TAPS = 11;
  localparam int DEPTH   = 72;
  localparam int ADDR_W  = 7;
  localparam int CNT_W   = 4;
  localparam int WIN     = 64;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [ADDR_W-1:0]  cmd_base_addr = '0;
  logic [CNT_W-1:0]   cmd_n_taps = '0;
  logic               cmd_clear = 1'b0;
  logic               pause = 1'b0;
  logic               buf_rEn_n;
  logic [ADDR_W-1:0]  buf_rAddr;
  logic [NB_TAPS-1:0] weight_load_en;
  logic               clear_all_wregs;
  logic               busy;
  logic               done;
  logic               cmd_err;

  int nTests = 0;
  int nFail  = 0;
  logic [ADDR_W-1:0] mAddr = '0;

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [CNT_W-1:0]  n;
    logic              clr;
    int                expDone;
    logic              expErr;
  } vec_t;
  vec_t vecs[7];

  wbuff_tap_load_seq #(
    .NB_TAPS(NB_TAPS), .BUFFER_DEPTH(DEPTH), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_base_addr(cmd_base_addr), .cmd_n_taps(cmd_n_taps), .cmd_clear(cmd_clear),
    .pause(pause), .buf_rEn_n(buf_rEn_n), .buf_rAddr(buf_rAddr),
    .weight_load_en(weight_load_en), .clear_all_wregs(clear_all_wregs),
    .busy(busy), .done(done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int off,
                             input logic [31:0] act, input logic [31:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s at +%0d: got 0x%0h, expected 0x%0h", name, off, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_ready"}, 0, cmd_ready, 1);
    checkOutput({tag, "_rEn_n"}, 0, buf_rEn_n, 1);
    checkOutput({tag, "_addr"},  0, buf_rAddr, 0);
    checkOutput({tag, "_ld"},    0, weight_load_en, 0);
    checkOutput({tag, "_clr"},   0, clear_all_wregs, 0);
    checkOutput({tag, "_busy"},  0, busy, 0);
    checkOutput({tag, "_done"},  0, done, 0);
    checkOutput({tag, "_err"},   0, cmd_err, 0);
  endtask

  // Issues one command in the current (idle) cycle T and checks every output for each
  // following cycle against a timeline built from the command and the pause pattern
  // (pz bit j = pause during cycle T+j).
  task automatic applyStimulus(input logic [ADDR_W-1:0] b, input logic [CNT_W-1:0] n,
                               input logic c, input logic [WIN-1:0] pz, input bit noise,
                               output int doneOff, output bit errSeen);
    logic               eRd[WIN];
    int                 rdA[WIN];
    logic [ADDR_W-1:0]  eAddr[WIN];
    logic [NB_TAPS-1:0] eLd[WIN];
    logic               eClr[WIN], eBusy[WIN], eDone[WIN], eErr[WIN], eRdy[WIN];
    int                 last, dExp, cyc;
    logic [ADDR_W-1:0]  a;
    for (int i = 0; i < WIN; i++) begin
      eRd[i] = 0; rdA[i] = 0; eLd[i] = '0; eClr[i] = 0; eBusy[i] = 0;
      eDone[i] = 0; eErr[i] = 0; eRdy[i] = 1;
    end
    if (n == 0 || n > NB_TAPS) begin
      eErr[1] = 1; eDone[1] = 1; eBusy[1] = 1;
      dExp = 1; last = 2;
    end else begin
      cyc = c ? 2 : 1;
      if (c) eClr[1] = 1;
      for (int k = 0; k < int'(n); k++) begin
        if (k > 0) begin
          cyc++;
          while (pz[cyc-1]) cyc++;
        end
        eRd[cyc] = 1;
        rdA[cyc] = (int'(b) + k) % DEPTH;
        eLd[cyc+1] = NB_TAPS'(1) << k;
      end
      dExp = cyc + 2;
      eDone[dExp] = 1;
      for (int i = 1; i <= dExp; i++) eBusy[i] = 1;
      for (int i = 1; i < dExp; i++) eRdy[i] = 0;
      last = dExp + 1;
    end
    a = mAddr;
    for (int i = 0; i < WIN; i++) begin
      if (eRd[i]) a = ADDR_W'(rdA[i]);
      eAddr[i] = a;
    end
    mAddr = a;

    checkOutput("ready_at_accept", 0, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_base_addr = b; cmd_n_taps = n; cmd_clear = c; pause = pz[0];
    doneOff = -1; errSeen = 0;
    for (int off = 1; off <= last; off++) begin
      step();
      checkOutput("rEn_n", off, buf_rEn_n, !eRd[off]);
      checkOutput("rAddr", off, buf_rAddr, eAddr[off]);
      checkOutput("load_en", off, weight_load_en, eLd[off]);
      checkOutput("clear", off, clear_all_wregs, eClr[off]);
      checkOutput("busy", off, busy, eBusy[off]);
      checkOutput("done", off, done, eDone[off]);
      checkOutput("cmd_err", off, cmd_err, eErr[off]);
      checkOutput("cmd_ready", off, cmd_ready, eRdy[off]);
      if (done === 1'b1 && doneOff < 0) doneOff = off;
      if (cmd_err === 1'b1) errSeen = 1;
      cmd_valid     = (noise && off < dExp) ? 1'($urandom) : 1'b0;
      cmd_base_addr = ADDR_W'($urandom);
      cmd_n_taps    = CNT_W'($urandom);
      cmd_clear     = 1'($urandom);
      pause         = pz[off];
    end
  endtask

  initial begin
    int  dOff;
    bit  eSeen;
    logic [WIN-1:0] pz;

    vecs[0] = '{7'd5,  4'd3,  1'b0, 5,  1'b0};
    vecs[1] = '{7'd0,  4'd11, 1'b1, 14, 1'b0};
    vecs[2] = '{7'd70, 4'd4,  1'b0, 6,  1'b0};
    vecs[3] = '{7'd3,  4'd0,  1'b0, 1,  1'b1};
    vecs[4] = '{7'd3,  4'd12, 1'b0, 1,  1'b1};
    vecs[5] = '{7'd71, 4'd1,  1'b1, 4,  1'b0};
    vecs[6] = '{7'd65, 4'd11, 1'b0, 13, 1'b0};

    step();
    step();
    checkResetValues("reset");
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].base, vecs[i].n, vecs[i].clr, '0, 1'b0, dOff, eSeen);
      checkOutput("vec_done_offset", i, dOff, vecs[i].expDone);
      checkOutput("vec_err_seen", i, eSeen, vecs[i].expErr);
    end

    // Pause during T+3 and T+4 delays the remaining reads by two cycles.
    pz = '0;
    pz[3] = 1'b1;
    pz[4] = 1'b1;
    applyStimulus(7'd20, 4'd5, 1'b0, pz, 1'b0, dOff, eSeen);
    checkOutput("pause_done_offset", 0, dOff, 9);

    // Reset lands in the middle of the third read of a six-tap command.
    cmd_valid = 1'b1; cmd_base_addr = 7'd10; cmd_n_taps = 4'd6; cmd_clear = 1'b0; pause = 1'b0;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    checkOutput("rst_third_read", 3, {buf_rEn_n, buf_rAddr}, {1'b0, 7'd12});
    #2 rst_n = 1'b0;
    #1 checkResetValues("async_reset");
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("rst_no_load", i, weight_load_en, 0);
      checkOutput("rst_no_done", i, done, 0);
    end
    rst_n = 1'b1;
    mAddr = '0;
    applyStimulus(7'd40, 4'd6, 1'b0, '0, 1'b0, dOff, eSeen);
    checkOutput("post_reset_done", 0, dOff, 8);

    for (int t = 0; t < 40; t++) begin
      pz = {32'b0, $urandom & $urandom};
      applyStimulus(ADDR_W'($urandom_range(0, DEPTH - 1)), CNT_W'($urandom_range(0, 12)),
                    1'($urandom_range(0, 1)), pz, 1'b1, dOff, eSeen);
    end

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
